dmem_responder: RTL and testbench



---
 rtl/dmem_responder_if.sv | 31 +++
 rtl/dmem_responder.sv | 170 +++++++++++++++++
 tb/tb_dmem_responder.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module : dmem_responder_if
// | Brief  : Request/response valid-ready bundle for the data-memory port.
// | Rev    : 1.0  initial release
// +----------------------------------------------------------------------------
interface dmem_responder_if #(
  parameter int ADDRW = 12
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [2:0]       req_funct3;
  logic [ADDRW-1:0] req_addr;
  logic [31:0]      req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module : dmem_responder
// | Brief  : Byte-addressable RV32I data memory with fixed access latency and
// |          one outstanding transaction. DMEM_MISALIGN_CHECK_EN rejects
// |          misaligned half/word accesses.
// | Rev    : 1.0  initial release
// +----------------------------------------------------------------------------
module dmem_responder #(
  parameter int ADDRW   = 12,
  parameter int LATENCY = 2
) (
  input  wire logic       clk,
  input  wire logic       rst,
  dmem_responder_if.slave bus
);
  localparam int         c_words   = 1 << (ADDRW - 2);
  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_wait = 2'd1;
  localparam logic [1:0] c_st_resp = 2'd2;

  logic [1:0]       r_state;
  logic [31:0]      r_mem [c_words];
  logic [31:0]      r_rdata;
  logic             r_err;

  logic             w_accept;
  logic             w_go_resp;
  logic             w_op_we;
  logic [2:0]       w_op_f3;
  logic [ADDRW-1:0] w_op_addr;
  logic [31:0]      w_op_wdata;

  assign w_accept      = bus.req_valid && (r_state == c_st_idle);
  assign bus.req_ready = (r_state == c_st_idle);
  assign bus.rsp_valid = (r_state == c_st_resp);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

  // With no wait cycles the commit edge is the accept edge, so operate on the live request.
  generate
    if (LATENCY == 0) begin : g_no_wait
      assign w_op_we    = bus.req_we;
      assign w_op_f3    = bus.req_funct3;
      assign w_op_addr  = bus.req_addr;
      assign w_op_wdata = bus.req_wdata;
      assign w_go_resp  = w_accept;
    end else begin : g_wait
      localparam int c_cntw = $clog2(LATENCY + 1);
      logic [c_cntw-1:0] r_cnt;
      logic              r_we;
      logic [2:0]        r_f3;
      logic [ADDRW-1:0]  r_addr;
      logic [31:0]       r_wdata;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt   <= '0;
          r_we    <= 1'b0;
          r_f3    <= 3'b000;
          r_addr  <= '0;
          r_wdata <= '0;
        end else if (w_accept) begin
          r_cnt   <= c_cntw'(LATENCY);
          r_we    <= bus.req_we;
          r_f3    <= bus.req_funct3;
          r_addr  <= bus.req_addr;
          r_wdata <= bus.req_wdata;
        end else if (r_state == c_st_wait) begin
          r_cnt   <= r_cnt - 1'b1;
        end
      end

      assign w_op_we    = r_we;
      assign w_op_f3    = r_f3;
      assign w_op_addr  = r_addr;
      assign w_op_wdata = r_wdata;
      assign w_go_resp  = (r_state == c_st_wait) && (r_cnt == c_cntw'(1));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      case (r_state)
        c_st_idle: if (w_accept)      r_state <= (LATENCY == 0) ? c_st_resp : c_st_wait;
        c_st_wait: if (w_go_resp)     r_state <= c_st_resp;
        c_st_resp: if (bus.rsp_ready) r_state <= c_st_idle;
        default:                      r_state <= c_st_idle;
      endcase
    end
  end

  logic [1:0]  w_size;
  logic [1:0]  w_boff;
  logic [3:0]  w_wmask;
  logic [4:0]  w_shamt;
  logic [31:0] w_word;
  logic [31:0] w_lane;
  logic [31:0] w_load;
  logic [31:0] w_wdata_sh;
  logic        w_bad_f3;
  logic        w_misalign;
  logic        w_err;
  logic        w_commit;

  assign w_size = w_op_f3[1:0];
  assign w_word = r_mem[w_op_addr[ADDRW-1:2]];

  // Sub-size address bits are dropped for half/word so the lane is always aligned.
  always_comb begin
    w_boff  = 2'b00;
    w_wmask = 4'b1111;
    case (w_size)
      2'd0: begin
        w_boff  = w_op_addr[1:0];
        w_wmask = 4'b0001 << w_op_addr[1:0];
      end
      2'd1: begin
        w_boff  = {w_op_addr[1], 1'b0};
        w_wmask = 4'b0011 << {w_op_addr[1], 1'b0};
      end
      default: ;
    endcase
  end

  assign w_shamt    = {w_boff, 3'b000};
  assign w_lane     = w_word >> w_shamt;
  assign w_wdata_sh = w_op_wdata << w_shamt;

  always_comb begin
    w_load = w_lane;
    case (w_size)
      2'd0:    w_load = {{24{!w_op_f3[2] && w_lane[7]}}, w_lane[7:0]};
      2'd1:    w_load = {{16{!w_op_f3[2] && w_lane[15]}}, w_lane[15:0]};
      default: w_load = w_lane;
    endcase
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  assign w_misalign = ((w_size == 2'd1) && w_op_addr[0]) ||
                      ((w_size == 2'd2) && (w_op_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_bad_f3 = (w_op_f3 == 3'b011) || (w_op_f3[2:1] == 2'b11);
  assign w_err    = w_bad_f3 || (w_op_we && w_op_f3[2]) || w_misalign;
  assign w_commit = w_go_resp && w_op_we && !w_err;

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_wmask[i]) r_mem[w_op_addr[ADDRW-1:2]][8*i +: 8] <= w_wdata_sh[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_go_resp) begin
      r_err   <= w_err;
      r_rdata <= (w_op_we || w_err) ? 32'h0 : w_load;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module : tb_dmem_responder
// | Brief  : Bench for dmem_responder at LATENCY=2 (dut 0) and LATENCY=0 (dut 1).
// | Rev    : 1.0  initial release
// +----------------------------------------------------------------------------
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v_valid [2];
  logic        v_we    [2];
  logic [2:0]  v_f3    [2];
  logic [11:0] v_addr  [2];
  logic [31:0] v_wd    [2];
  logic        v_rr    [2];
  logic        m_ready [2];
  logic        m_valid [2];
  logic        m_err   [2];
  logic [31:0] m_rdata [2];

  dmem_responder_if #(.ADDRW(12)) bus0 ();
  dmem_responder_if #(.ADDRW(12)) bus1 ();

  assign bus0.req_valid = v_valid[0];  assign bus1.req_valid = v_valid[1];
  assign bus0.req_we = v_we[0];        assign bus1.req_we = v_we[1];
  assign bus0.req_funct3 = v_f3[0];    assign bus1.req_funct3 = v_f3[1];
  assign bus0.req_addr = v_addr[0];    assign bus1.req_addr = v_addr[1];
  assign bus0.req_wdata = v_wd[0];     assign bus1.req_wdata = v_wd[1];
  assign bus0.rsp_ready = v_rr[0];     assign bus1.rsp_ready = v_rr[1];
  assign m_ready[0] = bus0.req_ready;  assign m_ready[1] = bus1.req_ready;
  assign m_valid[0] = bus0.rsp_valid;  assign m_valid[1] = bus1.rsp_valid;
  assign m_err[0] = bus0.rsp_err;      assign m_err[1] = bus1.rsp_err;
  assign m_rdata[0] = bus0.rsp_rdata;  assign m_rdata[1] = bus1.rsp_rdata;

  dmem_responder #(.ADDRW(12), .LATENCY(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  dmem_responder #(.ADDRW(12), .LATENCY(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // Reference model: byte array per dut, operation applied when the response becomes due.
  logic [7:0]  mm [2][4096];
  bit          busy [2];
  int          kc   [2];
  logic        s_we [2];
  logic [2:0]  s_f3 [2];
  logic [11:0] s_addr [2];
  logic [31:0] s_wd [2];
  logic [31:0] e_rdata [2];
  logic        e_err [2];

  task automatic mod_exec(input int d);
    int a, nb, base;
    logic [31:0] val;
    logic [2:0] f;
    f  = s_f3[d];
    a  = int'(s_addr[d]);
    nb = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    base = a - (a % nb);
    e_err[d] = (f == 3'b011) || (f == 3'b110) || (f == 3'b111) || (s_we[d] && f[2]);
`ifdef DMEM_MISALIGN_CHECK_EN
    if ((a % nb) != 0) e_err[d] = 1'b1;
`endif
    val = 32'h0;
    if (!e_err[d]) begin
      if (s_we[d]) begin
        for (int i = 0; i < nb; i++) mm[d][base + i] = s_wd[d][8*i +: 8];
      end else begin
        for (int i = 0; i < nb; i++) val[8*i +: 8] = mm[d][base + i];
        if (!f[2] && nb < 4 && val[8*nb - 1]) begin
          for (int i = nb; i < 4; i++) val[8*i +: 8] = 8'hFF;
        end
      end
    end
    e_rdata[d] = val;
  endtask

  initial begin
    busy[0] = 0; busy[1] = 0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          busy[d] = 0;
          chk("rst_req_ready", 32'(m_ready[d]), 32'd1);
          chk("rst_rsp_valid", 32'(m_valid[d]), 32'd0);
          chk("rst_rsp_rdata", m_rdata[d], 32'd0);
          chk("rst_rsp_err", 32'(m_err[d]), 32'd0);
        end else if (!busy[d]) begin
          chk("idle_req_ready", 32'(m_ready[d]), 32'd1);
          chk("idle_rsp_valid", 32'(m_valid[d]), 32'd0);
          if (v_valid[d]) begin
            busy[d] = 1; kc[d] = 0;
            s_we[d] = v_we[d]; s_f3[d] = v_f3[d]; s_addr[d] = v_addr[d]; s_wd[d] = v_wd[d];
          end
        end else begin
          kc[d]++;
          if (kc[d] == lat_of(d) + 1) mod_exec(d);
          chk("busy_req_ready", 32'(m_ready[d]), 32'd0);
          chk("rsp_valid_timing", 32'(m_valid[d]), 32'(kc[d] >= lat_of(d) + 1));
          if (kc[d] >= lat_of(d) + 1) begin
            chk("model_rsp_rdata", m_rdata[d], e_rdata[d]);
            chk("model_rsp_err", 32'(m_err[d]), 32'(e_err[d]));
            if (v_rr[d]) busy[d] = 0;
          end
        end
      end
    end
  end

  task automatic send(input int d, input bit we, input logic [2:0] f3, input logic [11:0] a,
                      input logic [31:0] wd, input bit keep);
    int t;
    t = 0;
    @(posedge clk); #1;
    v_valid[d] = 1'b1; v_we[d] = we; v_f3[d] = f3; v_addr[d] = a; v_wd[d] = wd;
    @(negedge clk);
    while (!m_ready[d] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!m_ready[d]) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: req_ready got 0 expected 1 (dut %0d)", d);
    end
    @(posedge clk); #1;
    if (!keep) v_valid[d] = 1'b0;
  endtask

  task automatic recv(input int d, input int hold, input bit lit, input logic [31:0] exp_d,
                      input bit exp_e, input string nm);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!m_valid[d] && lat < 100);
    chk({nm, "_latency"}, 32'(lat), 32'(lat_of(d) + 1));
    if (lit) chk({nm, "_req_ready_in_resp"}, 32'(m_ready[d]), 32'd0);
    repeat (hold) @(negedge clk);
    @(posedge clk); #1;
    v_rr[d] = 1'b1;
    @(negedge clk);
    if (lit) begin
      chk({nm, "_rdata"}, m_rdata[d], exp_d);
      chk({nm, "_err"}, 32'(m_err[d]), 32'(exp_e));
    end
    @(posedge clk); #1;
    v_rr[d] = 1'b0;
  endtask

  task automatic txn(input int d, input bit we, input logic [2:0] f3, input logic [11:0] a,
                     input logic [31:0] wd, input logic [31:0] exp_d, input bit exp_e,
                     input string nm);
    send(d, we, f3, a, wd, 1'b0);
    recv(d, 0, 1'b1, exp_d, exp_e, nm);
  endtask

  task automatic init_mem(input int d);
    for (int w = 0; w < 16; w++) txn(d, 1'b1, 3'b010, 12'(w * 4), $urandom, 32'h0, 1'b0, "init_sw");
  endtask

  task automatic random_traffic(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send(d, 1'($urandom), 3'($urandom), 12'($urandom_range(0, 63)), $urandom, 1'b0);
      recv(d, int'($urandom_range(0, 3)), 1'b0, 32'h0, 1'b0, "rnd");
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      v_valid[d] = 0; v_we[d] = 0; v_f3[d] = 0; v_addr[d] = 0; v_wd[d] = 0; v_rr[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    init_mem(0);
    txn(0, 1'b1, 3'b010, 12'h010, 32'hDEADBEEF, 32'h0, 1'b0, "sw_010");
    txn(0, 1'b0, 3'b010, 12'h010, 32'h0, 32'hDEADBEEF, 1'b0, "lw_010");
    txn(0, 1'b1, 3'b000, 12'h011, 32'h000000A5, 32'h0, 1'b0, "sb_011");
    txn(0, 1'b0, 3'b000, 12'h011, 32'h0, 32'hFFFFFFA5, 1'b0, "lb_011");
    txn(0, 1'b0, 3'b100, 12'h011, 32'h0, 32'h000000A5, 1'b0, "lbu_011");
    txn(0, 1'b0, 3'b010, 12'h010, 32'h0, 32'hDEADA5EF, 1'b0, "lw_after_sb");
    txn(0, 1'b1, 3'b001, 12'h012, 32'h00008001, 32'h0, 1'b0, "sh_012");
    txn(0, 1'b0, 3'b001, 12'h012, 32'h0, 32'hFFFF8001, 1'b0, "lh_012");
    txn(0, 1'b0, 3'b101, 12'h012, 32'h0, 32'h00008001, 1'b0, "lhu_012");
    txn(0, 1'b0, 3'b010, 12'h010, 32'h0, 32'h8001A5EF, 1'b0, "lw_after_sh");

    // Backpressure with the next request already waiting.
    send(0, 1'b0, 3'b010, 12'h010, 32'h0, 1'b1);
    recv(0, 5, 1'b1, 32'h8001A5EF, 1'b0, "lw_backpressure");
    @(negedge clk);
    chk("turnaround_req_ready", 32'(m_ready[0]), 32'd1);
    @(posedge clk); #1;
    v_valid[0] = 1'b0;
    recv(0, 0, 1'b1, 32'h8001A5EF, 1'b0, "lw_second");

`ifdef DMEM_MISALIGN_CHECK_EN
    txn(0, 1'b0, 3'b010, 12'h013, 32'h0, 32'h0, 1'b1, "lw_013");
`else
    txn(0, 1'b0, 3'b010, 12'h013, 32'h0, 32'h8001A5EF, 1'b0, "lw_013");
`endif
    txn(0, 1'b0, 3'b011, 12'h010, 32'h0, 32'h0, 1'b1, "ld_f3_011");
    txn(0, 1'b1, 3'b100, 12'h011, 32'h000000FF, 32'h0, 1'b1, "st_f3_100");
    txn(0, 1'b0, 3'b010, 12'h010, 32'h0, 32'h8001A5EF, 1'b0, "lw_unchanged");

    txn(0, 1'b1, 3'b010, 12'h020, 32'h0, 32'h0, 1'b0, "sw_020_zero");
    send(0, 1'b1, 3'b010, 12'h020, 32'h12345678, 1'b0);
    rst = 1'b1;
    #1;
    chk("midop_rst_rsp_valid", 32'(m_valid[0]), 32'd0);
    chk("midop_rst_req_ready", 32'(m_ready[0]), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    txn(0, 1'b0, 3'b010, 12'h020, 32'h0, 32'h0, 1'b0, "lw_020_discarded");

    init_mem(1);
    txn(1, 1'b1, 3'b010, 12'h010, 32'hDEADBEEF, 32'h0, 1'b0, "l0_sw_010");
    txn(1, 1'b0, 3'b010, 12'h010, 32'h0, 32'hDEADBEEF, 1'b0, "l0_lw_010");

    random_traffic(0, 150);
    random_traffic(1, 150);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
